piece_motion_controller: RTL

Sequences on-screen piece motion against the 640x480 VGA raster timing. Accepts single-cell move requests from game logic, validates them against screen bounds, and advances the piece position only at the start of vertical blanking so a frame never shows a half-updated position. Produces a per-pixel `piece_on` flag for the colour mux alongside the synchronizer's `video_on`.

---
 rtl/piece_motion_controller.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/piece_motion_controller.sv
// -----------------------------------------------------------------------------
// piece_motion_controller
//
// Moves an on-screen piece one cell at a time, in step with 640x480 VGA raster
// timing. Game logic issues single-cell move requests. Each request is checked
// against the screen bounds before it is accepted. The piece position changes
// only at the start of vertical blanking, so a visible frame never shows a
// half-updated position. The block also produces a per-pixel piece_on flag for
// the colour mux.
//
// Optional feature macro: PIECE_ANIM_SMOOTH_EN
//   defined   : the piece moves STEP_PX pixels per frame until a full cell is
//               covered (CELL_PX/STEP_PX frames).
//   undefined : the whole CELL_PX move is applied at the first blanking start
//               after the request is accepted.
//
// Ports
//   clk_refresh      pixel clock, shared with the h/v synchronizer
//   rst_n            synchronous active-low reset
//   pixelX, pixelY   current raster column / line
//   video_on         visible-area flag from the synchronizer
//   move_req         level request, held by the requester until move_ack
//   move_dir         00 right, 01 left, 10 down, 11 up
//   move_ack         one-cycle pulse when a request is consumed
//   move_err         one-cycle pulse with move_ack when the request is rejected
//   move_done        one-cycle pulse when an accepted move completes
//   busy             high while a move is in progress
//   frame_tick       one-cycle pulse at the start of vertical blanking
//   piece_x, piece_y top-left corner of the piece
//   piece_on         current pixel is inside the piece and in the visible area
// -----------------------------------------------------------------------------
module piece_motion_controller #(
  parameter int unsigned PIECE_SIZE = 32,
  parameter int unsigned CELL_PX    = 32,
  parameter int unsigned STEP_PX    = 4,
  parameter int unsigned X_MAX      = 640,
  parameter int unsigned Y_MAX      = 480
) (
  input  logic       clk_refresh,
  input  logic       rst_n,
  input  logic [9:0] pixelX,
  input  logic [9:0] pixelY,
  input  logic       video_on,
  input  logic       move_req,
  input  logic [1:0] move_dir,
  output logic       move_ack,
  output logic       move_err,
  output logic       move_done,
  output logic       busy,
  output logic       frame_tick,
  output logic [9:0] piece_x,
  output logic [9:0] piece_y,
  output logic       piece_on
);

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    DONE
  } state_e;

  // A cell move must be an exact number of smooth-mode steps.
  if ((CELL_PX % STEP_PX) != 0) begin : g_bad_step_cfg
    $error("CELL_PX must be a multiple of STEP_PX");
  end

  // 11-bit constants so bounds and window compares cannot overflow at the
  // right and bottom edges.
  localparam logic [10:0] CELL_W  = 11'(CELL_PX);
  localparam logic [10:0] PIECE_W = 11'(PIECE_SIZE);
  localparam logic [10:0] XMAX_W  = 11'(X_MAX);
  localparam logic [10:0] YMAX_W  = 11'(Y_MAX);
  localparam logic [9:0]  YBLANK  = 10'(Y_MAX);

`ifdef PIECE_ANIM_SMOOTH_EN
  localparam int unsigned STEPS  = CELL_PX / STEP_PX;
  localparam int unsigned CNT_W  = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);
  localparam logic [9:0]  DELTA  = 10'(STEP_PX);
`else
  localparam logic [9:0]  DELTA  = 10'(CELL_PX);
`endif

  state_e      state_q, state_d;
  logic [1:0]  dir_q, dir_d;
  logic [9:0]  piece_x_q, piece_x_d;
  logic [9:0]  piece_y_q, piece_y_d;
  logic        move_ack_q, move_ack_d;
  logic        move_err_q, move_err_d;
  logic        move_done_q, move_done_d;
  logic        busy_q, busy_d;
  logic        frame_tick_q, frame_tick_d;
  logic        piece_on_q, piece_on_d;
`ifdef PIECE_ANIM_SMOOTH_EN
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
`endif

  logic        blank_start;
  logic [10:0] cur_pos;
  logic [10:0] axis_lim;
  logic        target_ok;
  logic [10:0] px_w, py_w, x_w, y_w;

  // Bounds check for the requested move, evaluated on the current position.
  always_comb begin
    blank_start = (pixelX == '0) && (pixelY == YBLANK);
    cur_pos     = move_dir[1] ? {1'b0, piece_y_q} : {1'b0, piece_x_q};
    axis_lim    = move_dir[1] ? YMAX_W : XMAX_W;
    if (move_dir[0]) begin
      target_ok = (cur_pos >= CELL_W);
    end else begin
      target_ok = ((cur_pos + CELL_W + PIECE_W) <= axis_lim);
    end
  end

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    piece_x_d   = piece_x_q;
    piece_y_d   = piece_y_q;
    move_ack_d  = 1'b0;
    move_err_d  = 1'b0;
`ifdef PIECE_ANIM_SMOOTH_EN
    step_cnt_d  = step_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (move_req) begin
          move_ack_d = 1'b1;
          if (target_ok) begin
            dir_d   = move_dir;
            state_d = MOVE;
`ifdef PIECE_ANIM_SMOOTH_EN
            step_cnt_d = '0;
`endif
          end else begin
            move_err_d = 1'b1;
          end
        end
      end

      MOVE: begin
        if (blank_start) begin
          if (dir_q[1]) begin
            piece_y_d = dir_q[0] ? (piece_y_q - DELTA) : (piece_y_q + DELTA);
          end else begin
            piece_x_d = dir_q[0] ? (piece_x_q - DELTA) : (piece_x_q + DELTA);
          end
`ifdef PIECE_ANIM_SMOOTH_EN
          step_cnt_d = step_cnt_q + CNT_W'(1);
          if (step_cnt_q == LAST_STEP) begin
            state_d = DONE;
          end
`else
          state_d = DONE;
`endif
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // move_done is registered out of the DONE state, so it shows one cycle
    // after the final-step edge; busy is held through that cycle so it falls
    // only on the edge after move_done.
    move_done_d  = (state_q == DONE);
    busy_d       = (state_d != IDLE) || (state_q == DONE);
    frame_tick_d = blank_start;
  end

  always_comb begin
    px_w = {1'b0, pixelX};
    py_w = {1'b0, pixelY};
    x_w  = {1'b0, piece_x_q};
    y_w  = {1'b0, piece_y_q};
    piece_on_d = video_on
              && (px_w >= x_w) && (px_w < (x_w + PIECE_W))
              && (py_w >= y_w) && (py_w < (y_w + PIECE_W));
  end

  always_ff @(posedge clk_refresh) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      dir_q        <= '0;
      piece_x_q    <= '0;
      piece_y_q    <= '0;
      move_ack_q   <= 1'b0;
      move_err_q   <= 1'b0;
      move_done_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_tick_q <= 1'b0;
      piece_on_q   <= 1'b0;
`ifdef PIECE_ANIM_SMOOTH_EN
      step_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      piece_x_q    <= piece_x_d;
      piece_y_q    <= piece_y_d;
      move_ack_q   <= move_ack_d;
      move_err_q   <= move_err_d;
      move_done_q  <= move_done_d;
      busy_q       <= busy_d;
      frame_tick_q <= frame_tick_d;
      piece_on_q   <= piece_on_d;
`ifdef PIECE_ANIM_SMOOTH_EN
      step_cnt_q   <= step_cnt_d;
`endif
    end
  end

  assign move_ack   = move_ack_q;
  assign move_err   = move_err_q;
  assign move_done  = move_done_q;
  assign busy       = busy_q;
  assign frame_tick = frame_tick_q;
  assign piece_x    = piece_x_q;
  assign piece_y    = piece_y_q;
  assign piece_on   = piece_on_q;

endmodule
